vc_arbiter: RTL and testbench

- Moves words from NUM_SRC show-ahead virtual-channel FIFOs into two destination FIFOs (D0, D1), one word at a time.
- Sources are shared round-robin.
- A source is eligible only if its head word's destination FIFO is below the umbral_d threshold.
- Sits downstream of the init/idle/active/error control machine: enable is that machine's active_out, umbral_d is its umbralD_out.

---
 rtl/vc_arbiter.sv | 129 ++++++++++++
 tb/tb_vc_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// Round-robin mover from NUM_SRC show-ahead VC FIFOs into two destination FIFOs.
// A source competes only while its head word's destination is below umbral_d.
module vc_arbiter #(
   parameter int DATA_WIDTH = 6,
   parameter int NUM_SRC    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [3:0]                    umbral_d,
   input  logic [NUM_SRC-1:0]            src_empty,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   input  logic [3:0]                    dst_count0,
   input  logic [3:0]                    dst_count1,
   output logic [NUM_SRC-1:0]            src_pop,
   output logic [1:0]                    dst_push,
   output logic [DATA_WIDTH-1:0]         dst_data,
   output logic [NUM_SRC-1:0]            grant,
   output logic                          stall,
   output logic [1:0]                    state
);

   localparam int LW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [LW-1:0]           last_q, last_d;
   logic [NUM_SRC-1:0]      src_pop_q, src_pop_d;
   logic [1:0]              dst_push_q, dst_push_d;
   logic [DATA_WIDTH-1:0]   dst_data_q, dst_data_d;
   logic [NUM_SRC-1:0]      grant_q, grant_d;

   logic [1:0]              blocked;
   logic [NUM_SRC-1:0]      eligible;
   logic                    found;
   logic [LW-1:0]           sel;
   logic [LW-1:0]           idx;
   logic [DATA_WIDTH-1:0]   sel_word;
   logic                    sel_dst;
   logic                    any_nonempty;

   always_comb begin
      blocked[0] = (dst_count0 >= umbral_d);
      blocked[1] = (dst_count1 >= umbral_d);
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         eligible[k] = !src_empty[k] &&
                       !blocked[src_data[k*DATA_WIDTH + DATA_WIDTH - 1]];
      end
   end

   // Search starts just after the last winner, so the previous winner ranks last.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         idx = LW'((32'(last_q) + i) % NUM_SRC);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign sel_word     = src_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_dst      = sel_word[DATA_WIDTH-1];
   assign any_nonempty = |(~src_empty);

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      src_pop_d  = '0;
      dst_push_d = '0;
      dst_data_d = dst_data_q;
      grant_d    = '0;
      case (state_q)
         IDLE, PAUSE: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (found) begin
               state_d              = XFER;
               src_pop_d[sel]       = 1'b1;
               dst_push_d[sel_dst]  = 1'b1;
               dst_data_d           = sel_word;
               grant_d[sel]         = 1'b1;
               last_d               = sel;
            end else if (any_nonempty) begin
               state_d = PAUSE;
            end else begin
               state_d = IDLE;
            end
         end
         // XFER is always followed by a gap cycle so FIFO flags settle.
         XFER:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         last_q     <= LW'(NUM_SRC - 1);
         src_pop_q  <= '0;
         dst_push_q <= '0;
         dst_data_q <= '0;
         grant_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         src_pop_q  <= src_pop_d;
         dst_push_q <= dst_push_d;
         dst_data_q <= dst_data_d;
         grant_q    <= grant_d;
      end
   end

   assign src_pop  = src_pop_q;
   assign dst_push = dst_push_q;
   assign dst_data = dst_data_q;
   assign grant    = grant_q;
   assign stall    = (state_q == PAUSE);
   assign state    = state_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Randomised scoreboard bench for vc_arbiter: source FIFOs as queues, destinations
// as counters; the reference predicts each transfer from the arbitration rules.
module tb_vc_arbiter;

   localparam int DW = 6;
   localparam int NS = 4;
   localparam int S_IDLE = 0, S_XFER = 1, S_PAUSE = 2;

   logic              clk;
   logic              reset;
   logic              enable;
   logic [3:0]        umbral_d;
   logic [NS-1:0]     src_empty;
   logic [NS*DW-1:0]  src_data;
   logic [3:0]        dst_count0, dst_count1;
   logic [NS-1:0]     src_pop;
   logic [1:0]        dst_push;
   logic [DW-1:0]     dst_data;
   logic [NS-1:0]     grant;
   logic              stall;
   logic [1:0]        state;

   vc_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
      .clk(clk), .reset(reset), .enable(enable), .umbral_d(umbral_d),
      .src_empty(src_empty), .src_data(src_data),
      .dst_count0(dst_count0), .dst_count1(dst_count1),
      .src_pop(src_pop), .dst_push(dst_push), .dst_data(dst_data),
      .grant(grant), .stall(stall), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [DW-1:0] srcq [NS][$];
   logic [3:0]    dcount [2];
   logic [15:0]   sb [$];
   int            m_rr;
   bit            m_busy;
   int            exp_state_now;
   bit            p_valid;
   int            p_k, p_d, p_state;
   logic [DW-1:0] p_word;
   bit            c_valid;
   int            c_k, c_d;
   logic [DW-1:0] c_word;
   bit            rnd;
   bit            mon_on;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic predict_drive();
      logic [DW-1:0] w;
      bit any;
      p_valid = 0;
      p_state = S_IDLE;
      if (!m_busy && enable) begin
         any = 0;
         for (int i = 1; i <= NS; i++) begin
            int k;
            k = (m_rr + i) % NS;
            if (srcq[k].size() != 0) begin
               any = 1;
               w = srcq[k][0];
               if (!p_valid && !(dcount[w[DW-1]] >= umbral_d)) begin
                  p_valid = 1;
                  p_k     = k;
                  p_word  = w;
                  p_d     = int'(w[DW-1]);
               end
            end
         end
         p_state = p_valid ? S_XFER : (any ? S_PAUSE : S_IDLE);
      end
      for (int k = 0; k < NS; k++) begin
         src_empty[k] = (srcq[k].size() == 0);
         src_data[k*DW +: DW] = (srcq[k].size() != 0) ? srcq[k][0] : DW'($urandom);
      end
      dst_count0 = dcount[0];
      dst_count1 = dcount[1];
   endtask

   task automatic commit();
      logic [NS-1:0] oh;
      logic [1:0]    dh;
      exp_state_now = p_state;
      c_valid = p_valid;
      c_k = p_k; c_d = p_d; c_word = p_word;
      if (p_valid) begin
         oh = NS'(1) << p_k;
         dh = 2'(1) << p_d;
         sb.push_back({oh, oh, dh, p_word});
         void'(srcq[p_k].pop_front());
         dcount[p_d] = dcount[p_d] + 4'd1;
         m_rr = p_k;
      end
      m_busy = p_valid;
   endtask

   task automatic random_actions();
      for (int d = 0; d < 2; d++)
         if (dcount[d] != 0 && $urandom_range(2) == 0) dcount[d] = dcount[d] - 4'd1;
      if ($urandom_range(1) == 1) begin
         int k;
         k = int'($urandom_range(NS-1));
         if (srcq[k].size() < 4) srcq[k].push_back(DW'($urandom));
      end
      if ($urandom_range(15) == 0) enable = ($urandom_range(7) != 0);
      if ($urandom_range(31) == 0) umbral_d = 4'($urandom_range(6));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         commit();
         mon_on = 1;
         if (rnd) random_actions();
         predict_drive();
      end
   endtask

   task automatic load_all(input int per_src);
      for (int k = 0; k < NS; k++)
         for (int j = 0; j < per_src; j++) srcq[k].push_back(DW'($urandom));
   endtask

   // monitor: state/stall every cycle, transfers popped from the scoreboard
   always @(negedge clk) begin
      if (reset && mon_on) begin
         chk("state", 32'(state), 32'(exp_state_now));
         chk("stall", 32'(stall), 32'(exp_state_now == S_PAUSE));
         if (dst_push != 2'b00) begin
            if (sb.size() == 0) begin
               chk("unexpected_push", 32'(dst_push), 32'd0);
            end else begin
               logic [15:0] e;
               e = sb.pop_front();
               chk("xfer{grant,pop,push,data}", {16'd0, grant, src_pop, dst_push, dst_data}, {16'd0, e});
            end
         end else if (exp_state_now == S_XFER) begin
            chk("missing_push", 32'(dst_push), 32'd1);
         end
      end
   end

   initial begin
      bit hit;
      rnd = 0; mon_on = 0;
      reset = 1'b0; enable = 1'b0; umbral_d = 4'd4;
      src_empty = '1; src_data = '0; dst_count0 = '0; dst_count1 = '0;
      dcount[0] = '0; dcount[1] = '0;
      m_rr = NS - 1; m_busy = 0; exp_state_now = S_IDLE;
      p_valid = 0; p_state = S_IDLE; p_k = 0; p_d = 0; p_word = '0;

      #12;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_src_pop", 32'(src_pop), 32'd0);
      chk("rst_dst_push", 32'(dst_push), 32'd0);
      chk("rst_dst_data", 32'(dst_data), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);

      // single-source stream into D0
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b1;
      srcq[0].push_back(6'h05);
      srcq[0].push_back(6'h1a);
      srcq[0].push_back(6'h13);
      predict_drive();
      step(8);

      // round robin over all sources
      dcount[0] = '0; dcount[1] = '0; umbral_d = 4'd15;
      load_all(2);
      predict_drive();
      step(18);

      // backpressure: src0 -> D1 blocked, src1 -> D0 wins; then PAUSE; then unblock
      dcount[0] = 4'd0; dcount[1] = 4'd3; umbral_d = 4'd3;
      srcq[0].push_back(6'h2c);
      srcq[1].push_back(6'h0e);
      predict_drive();
      step(5);
      dcount[1] = 4'd2;
      predict_drive();
      step(3);

      // enable gating
      enable = 1'b0; dcount[0] = '0; dcount[1] = '0; umbral_d = 4'd8;
      load_all(1);
      predict_drive();
      step(5);
      enable = 1'b1;
      predict_drive();
      step(10);

      // zero threshold blocks everything
      umbral_d = 4'd0;
      srcq[2].push_back(6'h21);
      predict_drive();
      step(6);
      umbral_d = 4'd8; dcount[0] = '0; dcount[1] = '0;
      predict_drive();
      step(4);

      // reset in the middle of a transfer
      dcount[0] = '0; dcount[1] = '0; umbral_d = 4'd15;
      load_all(2);
      predict_drive();
      hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
         step(1);
         if (exp_state_now == S_XFER) hit = 1;
      end
      chk("reach_xfer_before_reset", 32'(hit), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_src_pop", 32'(src_pop), 32'd0);
      chk("async_rst_dst_push", 32'(dst_push), 32'd0);
      chk("async_rst_grant", 32'(grant), 32'd0);
      chk("async_rst_state", 32'(state), 32'd0);
      if (c_valid) begin
         srcq[c_k].push_front(c_word);
         dcount[c_d] = dcount[c_d] - 4'd1;
         void'(sb.pop_back());
      end
      m_busy = 0; m_rr = NS - 1; exp_state_now = S_IDLE;
      @(posedge clk);
      #2 reset = 1'b1;
      predict_drive();
      step(20);

      // randomised traffic
      rnd = 1;
      step(3000);
      rnd = 0;
      enable = 1'b0;
      predict_drive();
      step(3);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
